buffer_swap_ctrl: RTL and testbench
===================================

// Module: buffer_swap_ctrl
// PURPOSE
//  Sequences the back-to-front frame buffer copy in the double-buffered VGA path.
//  Waits for the processor's frame-complete flag, then for the VGA end-of-frame
//  edge, then streams every pixel from back buffer to front buffer.
//  Owns the back-buffer write port, and the processor's writes are arbitrated through it.
//  Drives the VGA source select and the swap handshake back to the processor.
// PARAMETERS
//  NUMBER_COLORS  9    palette size; CW = $clog2(NUMBER_COLORS)+1 colour bits
//  WIDTH          320  pixels per line
//  HEIGHT         240  lines per frame
//  AW             $clog2(WIDTH*HEIGHT)  pixel address width (17 at defaults)
// PORTS
//  clk        in   1   system clock; single clock domain
//  resetn     in   1   asynchronous, active-low reset
//  enable     in   1   copy enable, sampled at end-of-frame edge
//  trigger    in   1   VGA end-of-frame level; falling edge = frame boundary
//  done       in   1   processor: back-buffer frame complete (level)
//  cpu_we     in   1   processor write strobe
//  cpu_waddr  in   AW  processor write address
//  cpu_din    in   CW  processor write colour
//  cpu_busy   out  1   back-buffer port unavailable; cpu_we is dropped while high
//  swap       out  1   to processor: copy finished; held until done falls
//  bb_we      out  1   back-buffer write enable
//  bb_waddr   out  AW  back-buffer write address
//  bb_din     out  CW  back-buffer write colour
//  bb_raddr   out  AW  back-buffer read address (copy stream)
//  bb_dout    in   CW  back-buffer read data, 1-cycle synchronous latency
//  fb_we      out  1   front-buffer write enable
//  fb_waddr   out  AW  front-buffer write address
//  fb_din     out  CW  front-buffer write colour
//  select     out  1   VGA source: 1 = back buffer, 0 = front buffer
//  swap_count out  8   completed swaps, wraps 255->0
// BEHAVIOUR
//  Reset values:
//   - State is IDLE, and trig_q (registered trigger) is 0.
//   - The copy counter and all outputs are 0.
//  Frame edge: frame_edge = trig_q & ~trigger, evaluated every cycle.
//  FSM:
//   - IDLE: when done=1, go to ARMED on the next clk.
//   - ARMED: if done=0, return to IDLE. If frame_edge & enable & done, go to COPY
//     and clear the counter. Without enable, stay ARMED.
//   - COPY: bb_raddr = counter, incremented each cycle. After WIDTH*HEIGHT-1 is
//     issued, go to FLUSH.
//   - FLUSH: one cycle to retire the last pipelined write, then go to HANDSHAKE.
//   - HANDSHAKE: swap=1. When done=0, clear swap, increment swap_count, go to IDLE.
//  Copy pipeline:
//   - Read address issued at cycle n.
//   - At cycle n+1: fb_we=1, fb_waddr = address from n, fb_din = bb_dout.
//   - fb_we is high for exactly WIDTH*HEIGHT cycles per copy, and never outside COPY/FLUSH.
//  Arbitration:
//   - In IDLE, ARMED and HANDSHAKE, bb_we/bb_waddr/bb_din follow cpu_* combinationally.
//   - In COPY and FLUSH: cpu_busy=1, bb_we=0, and any cpu_we is discarded (not queued).
//  select: 1 in COPY and FLUSH, so VGA shows the frozen, complete back buffer; 0 otherwise.
//  Boundaries:
//   - A frame edge in the same cycle done first rises is ignored; ARMED waits for the next edge.
//   - done falling during COPY does not abort; the copy completes, and HANDSHAKE exits on the cycle after FLUSH.
//   - Frame edges during COPY, FLUSH or HANDSHAKE are ignored.
//   - Reset mid-copy: state returns to IDLE, and the counter and outputs clear.
//     No partial resume; the front buffer keeps whatever was already written.
// TESTING
//  1. Reset, done=0, 3 frame edges -> no fb_we, select=0, swap=0, cpu writes pass to bb_*.
//  2. done=1, enable=1, one frame edge -> exactly 76800 fb_we cycles.
//     fb_waddr runs 0..76799 and fb_din equals the pattern preloaded in the bb model.
//     swap=1; done=0 -> swap=0 and swap_count=1.
//  3. cpu_we=1 throughout a copy -> cpu_busy=1 and bb_we=0 for 76801 cycles.
//     The first write after FLUSH lands in bb.
//  4. enable=0 at the edge -> stays ARMED, no copy; enable=1 at the next edge -> copy starts.
//  5. resetn low at pixel 1000 of a copy -> all outputs 0 immediately, counter 0.
//     A new done plus edge restarts from address 0.
//  6. 256 back-to-back swaps -> swap_count wraps to 0; done dropped mid-copy -> swap pulses for 1 cycle.

Source files
------------

// File: rtl/buffer_swap_ctrl.sv
// Back-to-front frame buffer copy sequencer for the double-buffered VGA path.
// Arms on the processor's frame-complete flag, copies on the VGA frame edge, then handshakes.
module buffer_swap_ctrl #(
  parameter  int NUMBER_COLORS = 9,
  parameter  int WIDTH         = 320,
  parameter  int HEIGHT        = 240,
  parameter  int AW            = $clog2(WIDTH*HEIGHT),
  localparam int CW            = $clog2(NUMBER_COLORS) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          trigger,
  input  logic          done,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_waddr,
  input  logic [CW-1:0] cpu_din,
  output logic          cpu_busy,
  output logic          swap,
  output logic          bb_we,
  output logic [AW-1:0] bb_waddr,
  output logic [CW-1:0] bb_din,
  output logic [AW-1:0] bb_raddr,
  input  logic [CW-1:0] bb_dout,
  output logic          fb_we,
  output logic [AW-1:0] fb_waddr,
  output logic [CW-1:0] fb_din,
  output logic          select,
  output logic [7:0]    swap_count
);

  localparam logic [AW-1:0] LAST_PIX = AW'(WIDTH*HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COPY,
    S_FLUSH,
    S_HANDSHAKE
  } state_t;

  state_t          state_q;
  logic            trig_q;
  logic [AW-1:0]   cnt_q;
  logic            fb_we_q;
  logic [AW-1:0]   fb_waddr_q;
  logic [7:0]      swap_count_q;
  logic            frame_edge;
  logic            busy;

  assign frame_edge = trig_q & ~trigger;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      cnt_q        <= '0;
      fb_we_q      <= 1'b0;
      fb_waddr_q   <= '0;
      swap_count_q <= '0;
    end else begin
      trig_q  <= trigger;
      fb_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (done) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (!done) begin
            state_q <= S_IDLE;
          end else if (frame_edge && enable) begin
            state_q <= S_COPY;
            cnt_q   <= '0;
          end
        end
        S_COPY: begin
          // Read issued now; its data arrives next cycle alongside the delayed write.
          fb_we_q    <= 1'b1;
          fb_waddr_q <= cnt_q;
          if (cnt_q == LAST_PIX) begin
            state_q <= S_FLUSH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FLUSH: begin
          state_q <= S_HANDSHAKE;
        end
        S_HANDSHAKE: begin
          if (!done) begin
            state_q      <= S_IDLE;
            swap_count_q <= swap_count_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The copy owns the back-buffer port; processor writes are dropped, not queued.
  assign busy       = (state_q == S_COPY) || (state_q == S_FLUSH);
  assign cpu_busy   = busy;
  assign select     = busy;
  assign bb_we      = cpu_we & ~busy;
  assign bb_waddr   = cpu_waddr;
  assign bb_din     = cpu_din;
  assign bb_raddr   = cnt_q;
  assign fb_we      = fb_we_q;
  assign fb_waddr   = fb_waddr_q;
  assign fb_din     = fb_we_q ? bb_dout : '0;
  assign swap       = (state_q == S_HANDSHAKE);
  assign swap_count = swap_count_q;

endmodule

// File: tb/tb_buffer_swap_ctrl.sv
// Scoreboarded bench for buffer_swap_ctrl using a reduced frame so full copies stay short.
module tb_buffer_swap_ctrl;

  localparam int NC = 9;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(NC) + 1;

  logic          clk = 1'b0;
  logic          resetn, enable, trigger, done, cpu_we;
  logic [AW-1:0] cpu_waddr;
  logic [CW-1:0] cpu_din;
  logic          cpu_busy, swap, bb_we, fb_we, select;
  logic [AW-1:0] bb_waddr, bb_raddr, fb_waddr;
  logic [CW-1:0] bb_din, bb_dout, fb_din;
  logic [7:0]    swap_count;

  always #5 clk = ~clk;

  buffer_swap_ctrl #(.NUMBER_COLORS(NC), .WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .trigger(trigger), .done(done),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_din(cpu_din), .cpu_busy(cpu_busy),
    .swap(swap), .bb_we(bb_we), .bb_waddr(bb_waddr), .bb_din(bb_din),
    .bb_raddr(bb_raddr), .bb_dout(bb_dout), .fb_we(fb_we), .fb_waddr(fb_waddr),
    .fb_din(fb_din), .select(select), .swap_count(swap_count)
  );

  // Back-buffer memory model: synchronous read, preloadable pattern.
  logic [CW-1:0] bb_mem  [N];
  logic [CW-1:0] exp_mem [N];
  logic          preload = 1'b0;

  always @(posedge clk) begin
    bb_dout <= bb_mem[bb_raddr];
    if (preload) begin
      for (int i = 0; i < N; i++) bb_mem[i] <= CW'(i * 7 + 3);
    end else if (bb_we) begin
      bb_mem[bb_waddr] <= bb_din;
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [CW-1:0] d;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fbwe_cnt = 0;

  // Front-buffer write stream is checked against the scoreboard as it appears.
  always @(negedge clk) begin
    if (resetn === 1'b1 && fb_we === 1'b1) begin
      fbwe_cnt++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL fb_unexpected: fb_we=1 waddr=%0d din=%0d, required no write", fb_waddr, fb_din);
      end else begin
        mon_e = sb_q.pop_front();
        if (fb_waddr !== mon_e.a || fb_din !== mon_e.d) begin
          n_fail++;
          $display("FAIL fb_stream: waddr=%0d din=%0d, required waddr=%0d din=%0d",
                   fb_waddr, fb_din, mon_e.a, mon_e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
  endtask

  task automatic push_copy;
    for (int i = 0; i < N; i++) sb_q.push_back('{AW'(i), exp_mem[i]});
    fbwe_cnt = 0;
  endtask

  task automatic wait_swap(output int cycles);
    cycles = 0;
    while (swap !== 1'b1 && cycles < N + 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; enable = 1'b0; trigger = 1'b0; done = 1'b0;
    cpu_we = 1'b0; cpu_waddr = '0; cpu_din = '0;
    for (int i = 0; i < N; i++) exp_mem[i] = CW'(i * 7 + 3);
    preload = 1'b1;
    tick(); tick();
    preload = 1'b0;
    n_checks++;
    if ({fb_we, select, swap, cpu_busy, bb_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: we/sel/swap/busy/bbwe=%b, required 00000", {fb_we, select, swap, cpu_busy, bb_we});
    end
    n_checks++;
    if (bb_raddr !== '0 || fb_waddr !== '0 || fb_din !== '0 || swap_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: raddr=%0d fbaddr=%0d fbdin=%0d count=%0d, required all 0",
               bb_raddr, fb_waddr, fb_din, swap_count);
    end
    resetn = 1'b1;
    tick();
    for (int e = 0; e < 3; e++) begin
      frame_pulse();
      tick();
      n_checks++;
      if (select !== 1'b0 || swap !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_edge%0d: select=%b swap=%b, required 0 0", e, select, swap);
      end
    end
    cpu_we = 1'b1; cpu_waddr = AW'(5); cpu_din = CW'(17);
    #1;
    n_checks++;
    if (bb_we !== 1'b1 || bb_waddr !== AW'(5) || bb_din !== CW'(17)) begin
      n_fail++;
      $display("FAIL idle_passthru: bb_we=%b addr=%0d din=%0d, required 1 5 17", bb_we, bb_waddr, bb_din);
    end
    tick();
    exp_mem[5] = CW'(17);
    cpu_we = 1'b0;
    n_checks++;
    if (bb_mem[5] !== CW'(17)) begin
      n_fail++;
      $display("FAIL idle_write_landed: bb[5]=%0d, required 17", bb_mem[5]);
    end
  endtask

  task automatic test_copy;
    int cyc;
    done = 1'b1; enable = 1'b1;
    tick();
    push_copy();
    frame_pulse();
    n_checks++;
    if (select !== 1'b1 || cpu_busy !== 1'b1 || bb_raddr !== '0) begin
      n_fail++;
      $display("FAIL copy_start: select=%b busy=%b raddr=%0d, required 1 1 0", select, cpu_busy, bb_raddr);
    end
    wait_swap(cyc);
    n_checks++;
    if (swap !== 1'b1) begin
      n_fail++;
      $display("FAIL copy_swap: swap=%b after %0d cycles, required 1", swap, cyc);
    end
    n_checks++;
    if (fbwe_cnt !== N || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL copy_len: fb_we cycles=%0d left=%0d, required %0d 0", fbwe_cnt, sb_q.size(), N);
    end
    n_checks++;
    if (select !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_select: select=%b, required 0", select);
    end
    done = 1'b0;
    tick();
    n_checks++;
    if (swap !== 1'b0 || swap_count !== 8'd1) begin
      n_fail++;
      $display("FAIL copy_done: swap=%b count=%0d, required 0 1", swap, swap_count);
    end
  endtask

  task automatic test_cpu_blocked;
    int busy_cnt;
    int k;
    logic [CW-1:0] nd;
    nd = exp_mem[9] ^ CW'(5'h1F);
    done = 1'b1;
    tick();
    push_copy();
    frame_pulse();
    cpu_we = 1'b1; cpu_waddr = AW'(9); cpu_din = nd;
    busy_cnt = 0;
    k = 0;
    while (swap !== 1'b1 && k < N + 20) begin
      if (cpu_busy === 1'b1 && bb_we === 1'b0) busy_cnt++;
      trigger = k[0];
      tick();
      k++;
    end
    trigger = 1'b0;
    n_checks++;
    if (busy_cnt !== N + 1) begin
      n_fail++;
      $display("FAIL cpu_block_len: blocked cycles=%0d, required %0d", busy_cnt, N + 1);
    end
    n_checks++;
    if (fbwe_cnt !== N || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL block_copy_len: fb_we cycles=%0d left=%0d, required %0d 0", fbwe_cnt, sb_q.size(), N);
    end
    n_checks++;
    if (swap !== 1'b1 || bb_we !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_passthru: swap=%b bb_we=%b, required 1 1", swap, bb_we);
    end
    tick();
    exp_mem[9] = nd;
    cpu_we = 1'b0;
    n_checks++;
    if (bb_mem[9] !== nd) begin
      n_fail++;
      $display("FAIL post_copy_write: bb[9]=%0d, required %0d", bb_mem[9], nd);
    end
    done = 1'b0;
    tick();
    n_checks++;
    if (swap_count !== 8'd2) begin
      n_fail++;
      $display("FAIL block_count: count=%0d, required 2", swap_count);
    end
  endtask

  task automatic test_enable;
    int cyc;
    trigger = 1'b1;
    tick();
    trigger = 1'b0; done = 1'b1; enable = 1'b1;
    tick();
    tick(); tick();
    n_checks++;
    if (select !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_edge: select=%b, required 0", select);
    end
    enable = 1'b0;
    frame_pulse();
    tick();
    n_checks++;
    if (select !== 1'b0 || cpu_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled_edge: select=%b busy=%b, required 0 0", select, cpu_busy);
    end
    enable = 1'b1;
    push_copy();
    frame_pulse();
    n_checks++;
    if (select !== 1'b1) begin
      n_fail++;
      $display("FAIL enabled_edge: select=%b, required 1", select);
    end
    wait_swap(cyc);
    n_checks++;
    if (swap !== 1'b1 || fbwe_cnt !== N) begin
      n_fail++;
      $display("FAIL enable_copy: swap=%b fb_we cycles=%0d, required 1 %0d", swap, fbwe_cnt, N);
    end
    done = 1'b0;
    tick();
    n_checks++;
    if (swap_count !== 8'd3) begin
      n_fail++;
      $display("FAIL enable_count: count=%0d, required 3", swap_count);
    end
  endtask

  task automatic test_reset_mid_copy;
    int k;
    int cyc;
    done = 1'b1;
    tick();
    push_copy();
    frame_pulse();
    k = 0;
    while (bb_raddr !== AW'(10) && k < N + 5) begin
      tick();
      k++;
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({fb_we, select, swap, cpu_busy} !== 4'b0 || bb_raddr !== '0 || fb_waddr !== '0 ||
        fb_din !== '0 || swap_count !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: ctrl=%b raddr=%0d fbaddr=%0d fbdin=%0d count=%0d, required all 0",
               {fb_we, select, swap, cpu_busy}, bb_raddr, fb_waddr, fb_din, swap_count);
    end
    sb_q.delete();
    done = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    done = 1'b1;
    tick();
    push_copy();
    frame_pulse();
    n_checks++;
    if (bb_raddr !== '0 || select !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: raddr=%0d select=%b, required 0 1", bb_raddr, select);
    end
    wait_swap(cyc);
    n_checks++;
    if (swap !== 1'b1 || fbwe_cnt !== N || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_copy: swap=%b fb_we cycles=%0d left=%0d, required 1 %0d 0",
               swap, fbwe_cnt, sb_q.size(), N);
    end
    done = 1'b0;
    tick();
    n_checks++;
    if (swap_count !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_count: count=%0d, required 1", swap_count);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    for (int s = 0; s < 254; s++) begin
      done = 1'b1;
      tick();
      push_copy();
      frame_pulse();
      wait_swap(cyc);
      n_checks++;
      if (swap !== 1'b1 || fbwe_cnt !== N) begin
        n_fail++;
        $display("FAIL b2b_swap%0d: swap=%b fb_we cycles=%0d, required 1 %0d", s, swap, fbwe_cnt, N);
      end
      done = 1'b0;
      tick();
    end
    n_checks++;
    if (swap_count !== 8'd255) begin
      n_fail++;
      $display("FAIL b2b_count: count=%0d, required 255", swap_count);
    end
    done = 1'b1;
    tick();
    push_copy();
    frame_pulse();
    tick(); tick(); tick();
    done = 1'b0;
    wait_swap(cyc);
    n_checks++;
    if (swap !== 1'b1 || fbwe_cnt !== N || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_drop_copy: swap=%b fb_we cycles=%0d left=%0d, required 1 %0d 0",
               swap, fbwe_cnt, sb_q.size(), N);
    end
    tick();
    n_checks++;
    if (swap !== 1'b0 || swap_count !== 8'd0) begin
      n_fail++;
      $display("FAIL swap_pulse_wrap: swap=%b count=%0d, required 0 0", swap, swap_count);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_copy();
    test_cpu_blocked();
    test_enable();
    test_reset_mid_copy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
